seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider for signed or unsigned operands.
// One quotient bit is produced per cycle. A final cycle applies the sign
// fix-ups and the divide-by-zero substitution and registers the result, so
// every operation takes the same number of cycles whatever the operands are.
module seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            m_signed,
  input  logic            m_rem,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's-complement negation of an operand-width value.
  function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
    neg_f = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand: negative values are flipped only in signed mode.
  function automatic logic [XLEN-1:0] mag_f(input logic [XLEN-1:0] v, input logic sgn);
    if (sgn && v[XLEN-1]) begin
      mag_f = neg_f(v);
    end else begin
      mag_f = v;
    end
  endfunction

  state_t          state_q;
  logic [CW-1:0]   cnt_q;      // iterations completed so far
  logic [XLEN-1:0] quo_q;      // dividend bits shifted out at the top, quotient bits shifted in at the bottom
  logic [XLEN-1:0] rem_q;      // partial remainder, always below the divisor magnitude
  logic [XLEN-1:0] dsr_q;      // divisor magnitude
  logic [XLEN-1:0] dvd_q;      // original dividend, returned as the remainder on divide-by-zero
  logic            neg_quo_q;  // operand signs differ in signed mode
  logic            neg_rem_q;  // dividend negative in signed mode
  logic            dz_q;       // divisor was zero
  logic            rem_sel_q;  // return remainder instead of quotient
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] result_d;

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the (XLEN+1)-bit trial difference only if it did not go negative.
  always_comb begin
    shift_s = {rem_q, quo_q[XLEN-1]};
    trial_s = shift_s - {1'b0, dsr_q};
    if (trial_s[XLEN] == 1'b0) begin
      rem_d = trial_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      // A restore only happens when shift_s < divisor, so its top bit is zero.
      rem_d = shift_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  // Final fix-up: signs for truncating division, then the divide-by-zero
  // substitution. Signed overflow needs no special path: |MIN|/1 gives MIN,
  // and negating MIN gives MIN again with a zero remainder.
  always_comb begin
    if (neg_quo_q) begin
      quo_fix_s = neg_f(quo_q);
    end else begin
      quo_fix_s = quo_q;
    end
    if (neg_rem_q) begin
      rem_fix_s = neg_f(rem_q);
    end else begin
      rem_fix_s = rem_q;
    end
    if (dz_q) begin
      quo_fix_s = {XLEN{1'b1}};
      rem_fix_s = dvd_q;
    end else begin
      quo_fix_s = quo_fix_s;
      rem_fix_s = rem_fix_s;
    end
    if (rem_sel_q) begin
      result_d = rem_fix_s;
    end else begin
      result_d = quo_fix_s;
    end
  end

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      dsr_q     <= {XLEN{1'b0}};
      dvd_q     <= {XLEN{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      rem_sel_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // Capture everything needed so later input changes are irrelevant.
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= {CW{1'b0}};
            rem_q     <= {XLEN{1'b0}};
            quo_q     <= mag_f(dividend, m_signed);
            dsr_q     <= mag_f(divisor, m_signed);
            dvd_q     <= dividend;
            neg_quo_q <= m_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_rem_q <= m_signed & dividend[XLEN-1];
            dz_q      <= (divisor == {XLEN{1'b0}});
            rem_sel_q <= m_rem;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt_q == CW'(XLEN)) begin
            // All quotient bits present: publish the result this edge.
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= result_d;
          end else begin
            state_q <= S_RUN;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          // Any start seen here is dropped; a new one is taken from IDLE only.
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
